// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM serving CPU loads/stores after a fixed latency,
// stalling the CPU until done and flagging illegal requests without touching memory.
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  wr_q, wr_d, ill_q, ill_d;
  logic                  req, ill_in, capture, last, commit;
  logic [31:0]           mem [2**ADDR_WIDTH];
  always_comb begin
    req     = MemRead | MemWrite;
    ill_in  = (|addr[1:0]) | (|addr[31:ADDR_WIDTH+2]) | (MemRead & MemWrite);
    capture = (state_q == IDLE) & req;
    last    = (state_q == WAIT) & (cnt_q == 4'd0);
    commit  = last & wr_q & ~ill_q;
    state_d = capture ? WAIT : last ? IDLE : state_q;
    cnt_d   = capture ? 4'(LATENCY - 1) : ((state_q == WAIT) && (cnt_q != 4'd0)) ? cnt_q - 4'd1 : cnt_q;
    word_d  = capture ? addr[ADDR_WIDTH+1:2] : word_q;
    wdata_d = capture ? wdata : wdata_q;
    wr_d    = capture ? MemWrite : wr_q;
    ill_d   = capture ? ill_in : ill_q;
    rdata_d = (capture & MemRead & ~ill_in) ? mem[addr[ADDR_WIDTH+1:2]] : rdata_q;
    // reset forces the handshake low even while the CPU still drives a request
    stall   = rstn & ((state_q == IDLE) ? req : (cnt_q != 4'd0));
    done    = last;
    err     = last & ill_q;
    rdata   = rdata_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      word_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (commit) mem[word_q] <= wdata_q;
  end
endmodule
